// File: rtl/multu_if.sv
// Request/result bundle for the multi-cycle multiplier.
// Master drives operands, slave returns busy/done and HI/LO.
interface multu_if;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, sign, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, sign, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/multu.sv
// Radix-2 shift-add 32x32 multiplier, signed or unsigned.
// One partial product per cycle; result to HI/LO after 32.
module multu (
  input  logic   clk,
  input  logic   rst_n,
  multu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [64:0] p_q, p_d;
  logic [31:0] m_q, m_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        neg_q, neg_d;
  logic [5:0]  cnt_q, cnt_d;

  logic        accept;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] sum;
  logic [64:0] p_sh;
  logic [63:0] prod;

  assign accept = bus.start & (state_q != CALC);

  // 0x80000000 negates to itself, which is its magnitude unsigned
  assign abs_a = (bus.sign & bus.a[31]) ?
                 (~bus.a + 32'd1) : bus.a;
  assign abs_b = (bus.sign & bus.b[31]) ?
                 (~bus.b + 32'd1) : bus.b;

  assign sum  = p_q[0] ?
                ({1'b0, p_q[63:32]} + {1'b0, m_q}) :
                p_q[64:32];
  assign p_sh = {1'b0, sum, p_q[31:1]};
  assign prod = neg_q ?
                (~p_sh[63:0] + 64'd1) : p_sh[63:0];

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = CALC;
          p_d     = {33'd0, abs_b};
          m_d     = abs_a;
          neg_d   = bus.sign & (bus.a[31] ^ bus.b[31]);
          cnt_d   = 6'd0;
        end
      end
      CALC: begin
        p_d   = p_sh;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = DONE;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy = (state_q == CALC);
  assign bus.done = (state_q == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_multu.sv
// Directed self-checking bench for multu.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_multu;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  multu_if bus ();

  multu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start and wait (bounded) for done.
  // n = edges from accept to done; nb = busy samples.
  task automatic do_op(input logic [31:0] xa,
                       input logic [31:0] xb,
                       input logic        xs,
                       output int         n,
                       output int         nb);
    bus.start = 1'b1;
    bus.a     = xa;
    bus.b     = xb;
    bus.sign  = xs;
    tick();
    bus.start = 1'b0;
    n  = 0;
    nb = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.busy === 1'b1) nb++;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n, nb;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.sign  = 1'b1;
    bus.a     = $urandom;
    bus.b     = $urandom;
    repeat (3) tick();
    checks++;
    if ({bus.busy, bus.done} !== 2'b00 ||
        bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_vals: busy=%b done=%b hi=%h lo=%h want 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    bus.sign = 1'b0;
    bus.a    = 32'd3;
    bus.b    = 32'd5;
    rst_n    = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_start: busy=%b want 1", bus.busy);
    end
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (bus.lo !== 32'd15 || bus.hi !== 32'd0) begin
      errors++;
      $display("FAIL reset_first_op: hi=%h lo=%h want 0/f",
               bus.hi, bus.lo);
    end
    tick();
    nb = 0;
  endtask

  task automatic test_unsigned_max();
    int n, nb;
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, n, nb);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL umax_latency: got %0d want 32", n);
    end
    checks++;
    if (nb !== 32) begin
      errors++;
      $display("FAIL umax_busy_cycles: got %0d want 32", nb);
    end
    checks++;
    if (bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001) begin
      errors++;
      $display("FAIL umax_result: hi=%h lo=%h want fffffffe/00000001",
               bus.hi, bus.lo);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL umax_busy_in_done: busy=%b want 0", bus.busy);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 ||
        bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001) begin
      errors++;
      $display("FAIL umax_done_pulse: done=%b hi=%h lo=%h want 0 hold",
               bus.done, bus.hi, bus.lo);
    end
  endtask

  task automatic test_signed();
    int n, nb;
    do_op(32'hFFFFFFFF, 32'h00000002, 1'b1, n, nb);
    checks++;
    if (n !== 32 ||
        bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL signed_m1x2: n=%0d hi=%h lo=%h want 32 ffffffff/fffffffe",
               n, bus.hi, bus.lo);
    end
    tick();
    do_op(32'hFFFFFFFF, 32'h00000002, 1'b0, n, nb);
    checks++;
    if (n !== 32 ||
        bus.hi !== 32'h00000001 || bus.lo !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL unsigned_m1x2: n=%0d hi=%h lo=%h want 32 00000001/fffffffe",
               n, bus.hi, bus.lo);
    end
    tick();
  endtask

  task automatic test_signed_corner();
    int n, nb;
    do_op(32'h80000000, 32'h80000000, 1'b1, n, nb);
    checks++;
    if (n !== 32 ||
        bus.hi !== 32'h40000000 || bus.lo !== 32'h00000000) begin
      errors++;
      $display("FAIL corner_min_sq: n=%0d hi=%h lo=%h want 32 40000000/0",
               n, bus.hi, bus.lo);
    end
    tick();
    do_op(32'h80000000, 32'h00000001, 1'b1, n, nb);
    checks++;
    if (n !== 32 ||
        bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'h80000000) begin
      errors++;
      $display("FAIL corner_min_x1: n=%0d hi=%h lo=%h want 32 ffffffff/80000000",
               n, bus.hi, bus.lo);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n, nb, seen;
    bus.start = 1'b1;
    bus.sign  = 1'b0;
    bus.a     = 32'h12345678;
    bus.b     = 32'h9ABCDEF0;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00 ||
        bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL midrst_async: busy=%b done=%b hi=%h lo=%h want 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    tick();
    tick();
    rst_n = 1'b1;
    seen  = 0;
    repeat (40) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrst_no_done: %0d active cycles want 0", seen);
    end
    do_op(32'h12345678, 32'h9ABCDEF0, 1'b0, n, nb);
    checks++;
    if (n !== 32 ||
        bus.hi !== 32'h0B00EA4E || bus.lo !== 32'h242D2080) begin
      errors++;
      $display("FAIL midrst_rerun: n=%0d hi=%h lo=%h want 32 0b00ea4e/242d2080",
               n, bus.hi, bus.lo);
    end
    tick();
  endtask

  task automatic test_handshake();
    int n, bad;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.start = 1'b1;
    bus.sign  = 1'b0;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (n == 10) begin
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      n++;
    end
    bus.start = 1'b0;
    checks++;
    if (n !== 32 || bus.hi !== 32'd0 || bus.lo !== 32'd15) begin
      errors++;
      $display("FAIL hs_ignored_start: n=%0d hi=%h lo=%h want 32 0/f",
               n, bus.hi, bus.lo);
    end
    bus.start = 1'b1;
    bus.a     = 32'd7;
    bus.b     = 32'd0;
    tick();
    bus.start = 1'b0;
    bus.a     = 32'hDEADBEEF;
    bus.b     = 32'h12345678;
    n   = 1;
    bad = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.busy !== 1'b1 ||
          bus.hi !== 32'd0 || bus.lo !== 32'd15) bad++;
      tick();
      n++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hs_hold: %0d bad cycles want 0", bad);
    end
    checks++;
    if (n !== 33 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL hs_back_to_back: gap=%0d hi=%h lo=%h want 33 0/0",
               n, bus.hi, bus.lo);
    end
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_unsigned_max();
    test_signed();
    test_signed_corner();
    test_reset_mid();
    test_handshake();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/multu.md
# multu

Multi-cycle 32x32 multiplier for the CPU-54 execute stage. Computes the 64-bit product of two 32-bit operands with a radix-2 shift-add datapath: one partial product per cycle. Supports unsigned (MULTU) and signed (MULT) operation. Results go to the HI/LO register pair. The core stalls on `busy`, which is the multiplicative counterpart to the combinational unsigned divider.

## Interface
- No parameters; width fixed at 32-bit operands and a 64-bit product.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request; sampled only when `busy`=0.
- `sign`  in  1  1 = treat `a`,`b` as two's complement; 0 = unsigned. Sampled with `start`.
- `a`  in  32  multiplicand; sampled with `start`.
- `b`  in  32  multiplier; sampled with `start`.
- `busy`  out  1  operation in progress; start ignored.
- `done`  out  1  one-cycle pulse; `hi`/`lo` hold a new product.
- `hi`  out  32  product[63:32]; holds until next completion.
- `lo`  out  32  product[31:0]; holds until next completion.

## Operation
- States: IDLE, CALC, DONE.
- **Reset state.** While `rst_n`=0, asynchronously:
  - state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0;
  - iteration counter=0 and internal datapath registers=0.
- **Accepting a start.** A start is accepted on any edge where `start`=1 and state is IDLE or DONE; `busy` is low in both states. On acceptance:
  - if `sign`=1, load |a| and |b| as 32-bit magnitudes, where |0x80000000| = 0x80000000 interpreted unsigned;
  - if `sign`=1, record neg = a[31]^b[31]; otherwise neg=0 and the operands load unchanged;
  - product register P[64:0] = {33'b0, |b|}, multiplicand M = |a|, counter=0, state→CALC.
- **CALC iteration.** Each edge in CALC performs:
  - if P[0]=1, P[64:32] = P[63:32] + M, a 33-bit sum; otherwise unchanged;
  - then P = P >> 1 (logical);
  - counter increments.
- **CALC exit.** On the edge that completes the 32nd iteration:
  - {hi,lo} = neg ? (~P[63:0] + 1) : P[63:0], modulo 2^64;
  - state→DONE.
- **DONE.** DONE lasts exactly one cycle with `done`=1. Next state is CALC if a start is accepted on that edge, otherwise IDLE.
- **Ignored starts.** `start` during CALC is ignored and not queued. Operand changes during CALC do not affect the result.
- **Output stability.** `hi`/`lo` change only on the DONE-entry edge or on reset. A start accepted in DONE does not disturb the `hi`/`lo` just produced.
- **Reset mid-operation.** The operation is discarded and no `done` is issued. The next op after reset release behaves normally.
- Signed overflow cannot occur: the 64-bit product of two 32-bit values always fits.

## Timing
- Let E0 be the edge at which the start is accepted.
- `busy`=1 from after E0 through E32; iterations occur at E1..E32, so the CALC-exit edge is E32.
- `done`=1 and `hi`/`lo` valid from after E32 through E33, where E33 is the edge that leaves DONE; `busy`=0 in that cycle.
- Fixed latency of 32 cycles, start edge to `done`, independent of operand values; there is no early termination.
- Throughput: one op per 33 cycles when a new start is issued in the `done` cycle.
- All outputs are registered: `busy` and `done` decode from state flops, and there is no combinational path from inputs to outputs.
- Asynchronous assertion of `rst_n` takes effect immediately. Deassertion is synchronous to `clk` by the integrating design; the first acceptable start is on the first edge after release.

## Test plan
- **Reset values:** hold `rst_n`=0 with random inputs and `start`=1 → `busy`=0, `done`=0, `hi`=0, `lo`=0. After release, `start` is accepted on the next edge.
- **Unsigned max and latency:** a=b=0xFFFFFFFF, `sign`=0 → hi=0xFFFFFFFE, lo=0x00000001. `done` is high exactly in the cycle after E32 and `busy` is high exactly 32 cycles.
- **Signed vs unsigned:** a=0xFFFFFFFF, b=0x00000002.
  - `sign`=1 → hi=0xFFFFFFFF, lo=0xFFFFFFFE (i.e. -2).
  - `sign`=0 → hi=0x00000001, lo=0xFFFFFFFE.
- **Signed corner:** a=b=0x80000000, `sign`=1 → hi=0x40000000, lo=0x00000000. a=0x80000000, b=0x00000001, `sign`=1 → hi=0xFFFFFFFF, lo=0x80000000.
- **Handshake:**
  - start 3*5; pulse `start` with a=9,b=9 at cycle 10 → ignored, result hi=0, lo=15.
  - Issue start 7*0 in the `done` cycle → hi/lo remain 0/15 for 32 cycles, then hi=0, lo=0 with a second `done` exactly 33 cycles after the first.
- **Reset mid-op:** start 0x12345678*0x9ABCDEF0 unsigned; assert `rst_n`=0 after 10 CALC cycles → all outputs 0 immediately, and no `done` pulse.
  - Release and rerun the same operands → hi=0x0B00EA4E, lo=0x242D2080, 32 cycles after the start edge.
